// File: rtl/alu_pkg.sv
// Shared opcode constants, loader FSM state type and opcode validity helper
// for the alu / alu_operand_loader pair.
package alu_pkg;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

    typedef enum logic [1:0] {
        S_A   = 2'b00,
        S_B   = 2'b01,
        S_OP  = 2'b10,
        S_RES = 2'b11
    } state_t;

    function automatic logic is_valid_opcode(input logic [5:0] op);
        logic valid;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: valid = 1'b1;
            default:                        valid = 1'b0;
        endcase
        return valid;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU driven by the operand loader; unsupported opcodes yield 0.
// Shifts move d0 by the amount held in d1.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned N_BITS = 8
) (
    input  logic [N_BITS-1:0] d0,
    input  logic [N_BITS-1:0] d1,
    input  logic [5:0]        opcode,
    output logic [N_BITS-1:0] out
);

    always_comb begin
        out = '0;
        case (opcode)
            OP_ADD:  out = d0 + d1;
            OP_SUB:  out = d0 - d1;
            OP_AND:  out = d0 & d1;
            OP_OR:   out = d0 | d1;
            OP_XOR:  out = d0 ^ d1;
            OP_NOR:  out = ~(d0 | d1);
            OP_SRA:  out = $unsigned($signed(d0) >>> d1);
            OP_SRL:  out = d0 >> d1;
            default: out = '0;
        endcase
    end

endmodule

// File: rtl/btn_edge_detect.sv
// Two-flop synchroniser plus rising-edge detector for the load button.
// The pulse is registered so a press lands three edges after the raw rise.
module btn_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_pulse
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;
    logic pulse_q, pulse_d;

    always_comb begin
        meta_d  = i_btn;
        sync_d  = meta_q;
        prev_d  = sync_q;
        pulse_d = sync_q & ~prev_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign o_pulse = pulse_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Steps d0, d1 and opcode in from the switch bus on successive button presses,
// then captures the ALU result into a held register.
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int unsigned N_BITS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_BITS-1:0] i_sw,
    input  logic              i_btn,
    output logic [N_BITS-1:0] o_d0,
    output logic [N_BITS-1:0] o_d1,
    output logic [5:0]        o_opcode,
    input  logic [N_BITS-1:0] i_alu_out,
    output logic [N_BITS-1:0] o_result,
    output logic              o_done,
    output logic [1:0]        o_state,
    output logic              o_op_err
);

    logic btn_pulse;

    btn_edge_detect u_btn (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (i_btn),
        .o_pulse (btn_pulse)
    );

    state_t            state_q, state_d;
    logic [N_BITS-1:0] d0_q, d0_d;
    logic [N_BITS-1:0] d1_q, d1_d;
    logic [5:0]        opcode_q, opcode_d;
    logic [N_BITS-1:0] result_q, result_d;
    logic              done_q, done_d;
    logic              op_err_q, op_err_d;

    always_comb begin
        state_d  = state_q;
        d0_d     = d0_q;
        d1_d     = d1_q;
        opcode_d = opcode_q;
        result_d = result_q;
        done_d   = done_q;
        op_err_d = op_err_q;
        case (state_q)
            S_A: begin
                if (btn_pulse) begin
                    d0_d    = i_sw;
                    state_d = S_B;
                end
            end
            S_B: begin
                if (btn_pulse) begin
                    d1_d    = i_sw;
                    state_d = S_OP;
                end
            end
            S_OP: begin
                if (btn_pulse) begin
                    if (is_valid_opcode(i_sw[5:0])) begin
                        opcode_d = i_sw[5:0];
                        op_err_d = 1'b0;
                        state_d  = S_RES;
                    end else begin
                        op_err_d = 1'b1;
                    end
                end
            end
            S_RES: begin
                // done_q low marks the entry cycle: operands are stable, take the result.
                if (!done_q) begin
                    result_d = i_alu_out;
                    done_d   = 1'b1;
                end else if (btn_pulse) begin
                    done_d  = 1'b0;
                    d0_d    = i_sw;
                    state_d = S_B;
                end
            end
            default: state_d = S_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_A;
            d0_q     <= '0;
            d1_q     <= '0;
            opcode_q <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            op_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            d0_q     <= d0_d;
            d1_q     <= d1_d;
            opcode_q <= opcode_d;
            result_q <= result_d;
            done_q   <= done_d;
            op_err_q <= op_err_d;
        end
    end

    assign o_d0     = d0_q;
    assign o_d1     = d1_q;
    assign o_opcode = opcode_q;
    assign o_result = result_q;
    assign o_done   = done_q;
    assign o_state  = state_q;
    assign o_op_err = op_err_q;

endmodule

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
Upstream front-end for the combinational `alu` block. It loads operand d0, operand d1 and a 6-bit opcode from a shared switch bus. A single push-button steps it through the three loads.
- Drives the ALU inputs from registers.
- Captures the ALU result into a held output register for LEDs or downstream logic.
- Contains the button synchroniser/edge detector and a 4-state sequencing FSM.

Parameters:
N_BITS, 8, operand/result width; must be >= 6 so the opcode fits in the switch bus.

Ports:
clk  input  1  system clock; all logic is rising-edge.
reset  input  1  synchronous, active-high reset.
i_sw  input  N_BITS  switch bus; source of d0, d1 and opcode (opcode = i_sw[5:0]).
i_btn  input  1  asynchronous load button, active-high.
o_d0  output  N_BITS  operand A to the ALU `d0` input.
o_d1  output  N_BITS  operand B to the ALU `d1` input.
o_opcode  output  6  opcode to the ALU.
i_alu_out  input  N_BITS  combinational ALU result (`out`).
o_result  output  N_BITS  captured ALU result.
o_done  output  1  high while o_result holds the result of the current operand set.
o_state  output  2  current FSM state, for LEDs/debug.
o_op_err  output  1  sticky flag: last opcode load attempt was not a supported opcode.

Behaviour:
- Reset: a clock edge with reset=1 forces the following, regardless of state or button activity:
  - all outputs to 0, state to S_A;
  - both synchroniser flops and the edge-detector history flop to 0.
- Button path: i_btn passes through a 2-flop synchroniser.
  - btn_pulse = sync_q & ~prev_q, where prev_q is the registered sync_q. This is a 1-cycle pulse.
  - Latency from i_btn rising (set up before edge k) to the load taking effect: the load occurs at edge k+3.
  - A held button yields exactly one pulse.
  - No debounce: bounce filtering is the board wrapper's job.
- FSM states, encoded on o_state: S_A=00, S_B=01, S_OP=10, S_RES=11.
  - S_A, on btn_pulse: o_d0 <= i_sw; go to S_B.
  - S_B, on btn_pulse: o_d1 <= i_sw; go to S_OP.
  - S_OP, on btn_pulse with i_sw[5:0] in the supported set: o_opcode <= i_sw[5:0]; o_op_err <= 0; go to S_RES.
  - S_OP, on btn_pulse with i_sw[5:0] not in the set: o_op_err <= 1; o_opcode unchanged; stay in S_OP.
  - S_RES, first cycle: o_result <= i_alu_out at the end of that cycle. The ALU inputs are already stable, because they are registers loaded on the entry edge. o_done <= 1 at the same edge.
  - S_RES, on btn_pulse: clear o_done; o_d0 <= i_sw; go directly to S_B. This button press starts the next operation.
  - A btn_pulse on the S_RES entry cycle cannot occur: pulses are at least 2 cycles apart.
- Supported opcode set:
  - ADD 100000, SUB 100010, AND 100100, OR 100101;
  - XOR 100110, NOR 100111, SRA 000011, SRL 000010.
- Hold rules:
  - o_d0, o_d1 and o_opcode change only at their own load; they hold across all other states.
  - o_result holds until the next S_RES capture; it is not cleared by leaving S_RES.
  - o_done is low in every state except S_RES after capture.
- i_sw is only sampled at a load edge; it may change freely between presses.
- Widths: all data paths are exactly N_BITS. There is no extension or truncation except the opcode slice i_sw[5:0].

Decomposition:
- Package `alu_pkg`:
  - localparams for the 8 opcode values (shared with `alu` and the bench);
  - typedef enum logic [1:0] state_t {S_A, S_B, S_OP, S_RES};
  - function is_valid_opcode(logic [5:0]).
- Sub-module `btn_edge_detect`: ports clk, reset, i_btn, o_pulse; contains the synchroniser and the rising-edge detector.
- The loader instantiates `btn_edge_detect` once. The FSM and registers stay in the top module.
- The bench instantiates `alu_operand_loader` together with `alu`, with i_alu_out tied to `alu` out.

Test Plan:
- Reset then idle: after reset, with no button presses for 20 cycles -> o_state=00, and o_d0, o_d1, o_opcode, o_result, o_done, o_op_err all 0.
- ADD flow: press with i_sw=1, press with i_sw=1, press with i_sw=8'b00100000 -> o_opcode=100000, o_result=2, o_done=1 one cycle after entering S_RES. Repeat for SUB (4,1 -> 3) and NOR (8'hFE,8'hFE -> 1).
- Invalid opcode: in S_OP, press with i_sw[5:0]=111111 -> o_op_err=1, o_state stays 10, o_opcode unchanged. Then press with 100101 on operands 4,3 -> o_op_err=0, o_result=7.
- Held button: hold i_btn high for 50 cycles in S_A -> exactly one transition to S_B; o_d0 = i_sw sampled 3 edges after the rise.
- Back-to-back operations: from S_RES (result 2), press with i_sw=3 -> o_state=01, o_d0=3, o_done=0, o_result still 2 until the next S_RES capture.
- Reset mid-operation: assert reset in S_OP after loading d0=5, d1=6 -> next edge gives o_state=00 and all outputs 0. A following full sequence operates normally.
